pps_local_gen: RTL and testbench

Generates the local 1PPS from the disciplined system clock: a free-running second counter drives `_1PPS_Local`, the signal the phase-measurement block compares against the GPS 1PPS. The control loop steers it with one-shot signed phase adjustments of one period each, through a valid/ready handshake. An optional coarse-align mode snaps the counter to the next GPS rising edge.

---
 rtl/pps_local_gen.sv | 193 +++++++++++++++++++
 tb/tb_pps_local_gen.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pps_local_gen.sv
// rtl/pps_local_gen.sv - local 1PPS generator with one-shot signed phase steering
// Defining PPS_ALIGN_EN compiles in GPS coarse-align (synchronizer, ALIGN_WAIT state, Aligned flag).
module pps_local_gen #(
   parameter int CLK_FREQ    = 10_000_000,
   parameter int PULSE_WIDTH = 1_000_000,
   parameter int ADJ_MAX     = 1_000_000,
   parameter int CNT_W       = 24,
   parameter int ALIGN_OFS   = 2
) (
   input  logic             CLK_SYS,
   input  logic             CLK_RST,
   input  logic             _1PPS_GPS,
   input  logic             Align_Req,
   input  logic [CNT_W-1:0] Phase_Adj,
   input  logic             Adj_Valid,
   output logic             Adj_Ready,
   output logic             _1PPS_Local,
   output logic             PPS_Tick,
   output logic             Aligned
);

   localparam logic        [CNT_W-1:0] FREQ_C = CNT_W'(CLK_FREQ);
   localparam logic        [CNT_W-1:0] PW_C   = CNT_W'(PULSE_WIDTH);
   localparam logic        [CNT_W-1:0] OFS_C  = CNT_W'(ALIGN_OFS);
   localparam logic signed [CNT_W-1:0] ADJ_HI = CNT_W'(ADJ_MAX);
   localparam logic signed [CNT_W-1:0] ADJ_LO = -ADJ_HI;

   typedef enum logic {ST_RUN = 1'b0, ST_ALIGN_WAIT = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]        period_q, period_d;
   logic [CNT_W-1:0]        adj_pend_q, adj_pend_d;
   logic                    pend_q, pend_d;
   logic                    ready_q, ready_d;
   logic                    pps_q, pps_d;
   logic                    tick_q, tick_d;
   logic                    started_q, started_d;
   logic signed [CNT_W-1:0] adj_in, adj_clamped;
   logic                    wrap, accept;
   logic                    align_enter, align_load;

   assign wrap   = (cnt_q == period_q - 1'b1);
   assign accept = Adj_Valid & ready_q;

   always_comb begin
      adj_in      = $signed(Phase_Adj);
      adj_clamped = adj_in;
      if (adj_in > ADJ_HI) begin
         adj_clamped = ADJ_HI;
      end else if (adj_in < ADJ_LO) begin
         adj_clamped = ADJ_LO;
      end
   end

`ifdef PPS_ALIGN_EN
   // e0/e1 are the synchronized GPS level and its one-cycle-delayed copy.
   logic gps_meta_q, gps_meta_d;
   logic e0_q, e0_d;
   logic e1_q, e1_d;
   logic aligned_q, aligned_d;
   logic gps_edge;

   assign gps_edge = e0_q & ~e1_q;

   always_comb begin
      state_d     = state_q;
      align_enter = 1'b0;
      align_load  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (Align_Req) begin
               state_d     = ST_ALIGN_WAIT;
               align_enter = 1'b1;
            end
         end
         ST_ALIGN_WAIT: begin
            if (gps_edge) begin
               state_d    = ST_RUN;
               align_load = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      gps_meta_d = _1PPS_GPS;
      e0_d       = gps_meta_q;
      e1_d       = e0_q;
      aligned_d  = aligned_q;
      if (align_enter) begin
         aligned_d = 1'b0;
      end else if (align_load) begin
         aligned_d = 1'b1;
      end
   end

   always_ff @(posedge CLK_SYS) begin
      if (CLK_RST) begin
         gps_meta_q <= 1'b0;
         e0_q       <= 1'b0;
         e1_q       <= 1'b0;
         aligned_q  <= 1'b0;
      end else begin
         gps_meta_q <= gps_meta_d;
         e0_q       <= e0_d;
         e1_q       <= e1_d;
         aligned_q  <= aligned_d;
      end
   end

   assign Aligned = aligned_q;
`else
   logic unused_inputs;

   assign unused_inputs = _1PPS_GPS ^ Align_Req;

   always_comb begin
      state_d     = state_q;
      align_enter = 1'b0;
      align_load  = 1'b0;
   end

   assign Aligned = 1'b1;
`endif

   // The first cycle after reset only arms the counter, so the first pulse lands one edge later.
   always_comb begin
      started_d = 1'b1;
      cnt_d     = cnt_q;
      period_d  = period_q;
      if (started_q) begin
         if (align_load) begin
            cnt_d    = OFS_C;
            period_d = FREQ_C;
         end else if (wrap) begin
            cnt_d    = '0;
            period_d = pend_q ? (FREQ_C + adj_pend_q) : FREQ_C;
         end else begin
            cnt_d    = cnt_q + 1'b1;
         end
      end
   end

   // A wrap consumes the pending value; a transfer on the same wrap cycle queues for the next one.
   always_comb begin
      pend_d     = pend_q;
      adj_pend_d = adj_pend_q;
      if (wrap && pend_q) begin
         pend_d = 1'b0;
      end
      if (accept) begin
         pend_d     = 1'b1;
         adj_pend_d = $unsigned(adj_clamped);
      end
      if (align_enter) begin
         pend_d = 1'b0;
      end
      ready_d = (state_d == ST_RUN) & ~pend_d;
      pps_d   = started_q & (cnt_q < PW_C);
      tick_d  = started_q & (cnt_q == '0);
   end

   always_ff @(posedge CLK_SYS) begin
      if (CLK_RST) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         period_q   <= FREQ_C;
         adj_pend_q <= '0;
         pend_q     <= 1'b0;
         ready_q    <= 1'b1;
         pps_q      <= 1'b0;
         tick_q     <= 1'b0;
         started_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         period_q   <= period_d;
         adj_pend_q <= adj_pend_d;
         pend_q     <= pend_d;
         ready_q    <= ready_d;
         pps_q      <= pps_d;
         tick_q     <= tick_d;
         started_q  <= started_d;
      end
   end

   assign Adj_Ready   = ready_q;
   assign _1PPS_Local = pps_q;
   assign PPS_Tick    = tick_q;

endmodule

// File: tb/tb_pps_local_gen.sv
// tb/tb_pps_local_gen.sv - scoreboard bench for pps_local_gen
module tb_pps_local_gen;

   localparam int CLK_FREQ    = 1000;
   localparam int PULSE_WIDTH = 100;
   localparam int ADJ_MAX     = 50;
   localparam int CNT_W       = 24;
   localparam int ALIGN_OFS   = 2;

`ifdef PPS_ALIGN_EN
   localparam logic ALIGNED_RST = 1'b0;
`else
   localparam logic ALIGNED_RST = 1'b1;
`endif

   logic             clk       = 1'b0;
   logic             rst       = 1'b1;
   logic             gps       = 1'b0;
   logic             align_req = 1'b0;
   logic             adj_valid = 1'b0;
   logic [CNT_W-1:0] phase_adj = '0;
   logic             adj_ready;
   logic             pps;
   logic             tick;
   logic             aligned;

   int   cyc = -1;
   int   n_cmp = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   logic pps_prev = 1'b0;
   int   rise_cyc = 0;
   int   exp_rise[$];
   int   exp_width[$];
   int   exp_tick[$];

   pps_local_gen #(
      .CLK_FREQ   (CLK_FREQ),
      .PULSE_WIDTH(PULSE_WIDTH),
      .ADJ_MAX    (ADJ_MAX),
      .CNT_W      (CNT_W),
      .ALIGN_OFS  (ALIGN_OFS)
   ) dut (
      .CLK_SYS    (clk),
      .CLK_RST    (rst),
      ._1PPS_GPS  (gps),
      .Align_Req  (align_req),
      .Phase_Adj  (phase_adj),
      .Adj_Valid  (adj_valid),
      .Adj_Ready  (adj_ready),
      ._1PPS_Local(pps),
      .PPS_Tick   (tick),
      .Aligned    (aligned)
   );

   always #5 clk = ~clk;

   // Edge index: edge 0 is the first rising edge that samples reset low.
   always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

   task automatic expect_pulse(input int rise, input int width, input bit with_tick);
      exp_rise.push_back(rise);
      exp_width.push_back(width);
      if (with_tick) exp_tick.push_back(rise);
   endtask

   // Steps to the falling edge after edge n, scoring every output event on the way.
   task automatic advance_to(input int n);
      int e;
      while (cyc < n) begin
         @(negedge clk);
         if (mon_en && pps && !pps_prev) begin
            n_cmp++;
            if (exp_rise.size() == 0) begin
               n_fail++;
               $display("FAIL rise: rising edge at %0d, required none", cyc);
            end else begin
               e = exp_rise.pop_front();
               if (cyc !== e) begin
                  n_fail++;
                  $display("FAIL rise: rising edge at %0d, required %0d", cyc, e);
               end
            end
         end
         if (mon_en && !pps && pps_prev) begin
            n_cmp++;
            if (exp_width.size() == 0) begin
               n_fail++;
               $display("FAIL width: pulse of %0d ended at %0d, required none", cyc - rise_cyc, cyc);
            end else begin
               e = exp_width.pop_front();
               if (cyc - rise_cyc !== e) begin
                  n_fail++;
                  $display("FAIL width: pulse high %0d cycles, required %0d", cyc - rise_cyc, e);
               end
            end
         end
         if (mon_en && tick === 1'b1) begin
            n_cmp++;
            if (exp_tick.size() == 0) begin
               n_fail++;
               $display("FAIL tick: tick at %0d, required none", cyc);
            end else begin
               e = exp_tick.pop_front();
               if (cyc !== e) begin
                  n_fail++;
                  $display("FAIL tick: tick at %0d, required %0d", cyc, e);
               end
            end
         end
         if (pps && !pps_prev) rise_cyc = cyc;
         pps_prev = pps;
      end
   endtask

   task automatic scoreboard_close(input string tag);
      n_cmp++;
      if (exp_rise.size() + exp_width.size() + exp_tick.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: rise/width/tick left %0d/%0d/%0d, required 0/0/0",
                  tag, exp_rise.size(), exp_width.size(), exp_tick.size());
      end
      exp_rise.delete();
      exp_width.delete();
      exp_tick.delete();
      mon_en = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      n_cmp++;
      if (pps !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_pps: got %b, required 0", tag, pps);
      end
      n_cmp++;
      if (tick !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_tick: got %b, required 0", tag, tick);
      end
      n_cmp++;
      if (adj_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready: got %b, required 1", tag, adj_ready);
      end
      n_cmp++;
      if (aligned !== ALIGNED_RST) begin
         n_fail++;
         $display("FAIL %s_aligned: got %b, required %b", tag, aligned, ALIGNED_RST);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
   endtask

   task automatic test_free_run();
      for (int k = 0; k < 3; k++) expect_pulse(1 + k * CLK_FREQ, PULSE_WIDTH, 1'b1);
      mon_en = 1'b1;
      advance_to(2200);
      scoreboard_close("free_run");
   endtask

   task automatic test_adj_pos();
      expect_pulse(3001, PULSE_WIDTH, 1'b1);
      expect_pulse(3001 + CLK_FREQ + 20, PULSE_WIDTH, 1'b1);
      expect_pulse(3001 + 2 * CLK_FREQ + 20, PULSE_WIDTH, 1'b1);
      mon_en = 1'b1;
      advance_to(2499);
      phase_adj = 24'sd20;
      adj_valid = 1'b1;
      advance_to(2500);
      adj_valid = 1'b0;
      n_cmp++;
      if (adj_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL adj_pos_ready_low: got %b, required 0", adj_ready);
      end
      advance_to(2999);
      n_cmp++;
      if (adj_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL adj_pos_ready_held: got %b, required 0", adj_ready);
      end
      advance_to(3000);
      n_cmp++;
      if (adj_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL adj_pos_ready_back: got %b, required 1", adj_ready);
      end
      advance_to(5200);
      scoreboard_close("adj_pos");
   endtask

   task automatic test_adj_clamp();
      expect_pulse(6021, PULSE_WIDTH, 1'b1);
      expect_pulse(6021 + CLK_FREQ - ADJ_MAX, PULSE_WIDTH, 1'b1);
      expect_pulse(6021 + 2 * CLK_FREQ - ADJ_MAX, PULSE_WIDTH, 1'b1);
      mon_en = 1'b1;
      advance_to(5499);
      phase_adj = -24'sd200;
      adj_valid = 1'b1;
      advance_to(5500);
      adj_valid = 1'b0;
      advance_to(6020);
      n_cmp++;
      if (adj_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL adj_clamp_ready: got %b, required 1", adj_ready);
      end
      advance_to(8100);
      scoreboard_close("adj_clamp");
   endtask

   task automatic test_back_to_back_wrap();
      expect_pulse(8971, PULSE_WIDTH, 1'b1);
      expect_pulse(9971, PULSE_WIDTH, 1'b1);
      expect_pulse(9971 + CLK_FREQ + 10, PULSE_WIDTH, 1'b1);
      expect_pulse(9971 + 2 * CLK_FREQ + 10, PULSE_WIDTH, 1'b1);
      mon_en = 1'b1;
      advance_to(8969);
      phase_adj = 24'sd10;
      adj_valid = 1'b1;
      advance_to(8970);
      n_cmp++;
      if (adj_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_ready_low: got %b, required 0", adj_ready);
      end
      advance_to(8972);
      adj_valid = 1'b0;
      advance_to(9970);
      n_cmp++;
      if (adj_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_ready_back: got %b, required 1", adj_ready);
      end
      advance_to(12100);
      scoreboard_close("wrap");
   endtask

`ifdef PPS_ALIGN_EN
   task automatic test_align();
      advance_to(12099);
      align_req = 1'b1;
      advance_to(12100);
      align_req = 1'b0;
      n_cmp++;
      if (adj_ready !== 1'b0 || aligned !== 1'b0) begin
         n_fail++;
         $display("FAIL align_wait: ready/aligned %b/%b, required 0/0", adj_ready, aligned);
      end
      expect_pulse(12981, PULSE_WIDTH, 1'b1);
      expect_pulse(13383, PULSE_WIDTH - ALIGN_OFS, 1'b0);
      expect_pulse(14381, PULSE_WIDTH, 1'b1);
      mon_en = 1'b1;
      advance_to(12499);
      align_req = 1'b1;
      advance_to(12500);
      align_req = 1'b0;
      advance_to(13379);
      gps = 1'b1;
      advance_to(13381);
      n_cmp++;
      if (aligned !== 1'b0 || adj_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL align_early: aligned/ready %b/%b, required 0/0", aligned, adj_ready);
      end
      advance_to(13382);
      n_cmp++;
      if (aligned !== 1'b1 || adj_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL align_load: aligned/ready %b/%b, required 1/1", aligned, adj_ready);
      end
      advance_to(13500);
      gps = 1'b0;
      advance_to(14500);
      scoreboard_close("align");
   endtask
`endif

   task automatic test_reset_mid();
      advance_to(14599);
      phase_adj = 24'sd30;
      adj_valid = 1'b1;
      advance_to(14600);
      adj_valid = 1'b0;
      n_cmp++;
      if (adj_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_accept: ready got %b, required 0", adj_ready);
      end
`ifdef PPS_ALIGN_EN
      advance_to(14609);
      align_req = 1'b1;
      advance_to(14610);
      align_req = 1'b0;
`endif
      advance_to(14699);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("mid_reset");
      rst = 1'b0;
      for (int k = 0; k < 3; k++) expect_pulse(1 + k * CLK_FREQ, PULSE_WIDTH, 1'b1);
      mon_en = 1'b1;
      advance_to(2200);
      scoreboard_close("mid_reset");
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_adj_pos();
      test_adj_clamp();
      test_back_to_back_wrap();
`ifdef PPS_ALIGN_EN
      test_align();
`endif
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
